// File: rtl/axis_pkg.sv
// Shared types and helpers for the accumulator-to-DMA result packer.
package axis_pkg;

    localparam int DATA_W_DEFAULT = 32;

    // Per-byte keep value; every byte of every beat is valid.
    localparam logic KEEP_ALL = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; supports any depth and a
// simultaneous read and write while full.
module sync_fifo
    import axis_pkg::*;
#(
    parameter int DEPTH = 15,
    parameter int WIDTH = DATA_W_DEFAULT,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = level_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Index wraps at DEPTH (not a power of two in general); MSB flips on wrap.
    function automatic logic [AW:0] bump(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1))
            return {~p[AW], {AW{1'b0}}};
        else
            return {p[AW], p[AW-1:0] + AW'(1)};
    endfunction

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_comb begin
        if (wr_ptr[AW] == rd_ptr[AW])
            count = CW'(wr_ptr[AW-1:0]) - CW'(rd_ptr[AW-1:0]);
        else
            count = CW'(DEPTH) - CW'(rd_ptr[AW-1:0]) + CW'(wr_ptr[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= bump(wr_ptr);
            if (rd_ok) rd_ptr <= bump(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/axis_result_packer.sv
// Buffers accumulator results and streams them to the S2MM channel in
// PKT_LEN-beat frames, with a frame-done interrupt and sticky drop flag.
module axis_result_packer
    import axis_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int PKT_LEN    = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [DATA_W-1:0]               i_data,
    input  logic                            i_data_valid,
    input  logic                            i_flush,
    output logic [DATA_W-1:0]               m_axis_tdata,
    output logic [DATA_W/8-1:0]             m_axis_tkeep,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            o_intr,
    output logic                            o_overflow,
    output logic [level_w(FIFO_DEPTH)-1:0]  o_level
);

    localparam int LW    = level_w(FIFO_DEPTH);
    localparam int FW    = level_w(FIFO_DEPTH - 1);
    localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    out_state_t          state;
    out_state_t          state_n;
    logic [CNT_W-1:0]    cnt;
    logic                hs;
    logic                accept;
    logic                fifo_wr;
    logic                fifo_rd;
    logic                out_load;
    logic                bypass;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FW-1:0]       fifo_count;
    logic [DATA_W-1:0]   fifo_rdata;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH - 1),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .clr     (i_flush),
        .wr_en   (fifo_wr),
        .wr_data (i_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_axis_tkeep  = {(DATA_W/8){KEEP_ALL}};
    assign m_axis_tvalid = (state == ST_FULL);
    assign m_axis_tlast  = m_axis_tvalid && (cnt == CNT_W'(PKT_LEN - 1));
    assign hs            = m_axis_tvalid && m_axis_tready;
    // FIFO full implies the output register is full too, so this is level < FIFO_DEPTH.
    assign accept        = i_data_valid && (!fifo_full || hs);
    assign o_level       = LW'(fifo_count) + LW'(m_axis_tvalid);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= ST_EMPTY;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        fifo_wr  = 1'b0;
        fifo_rd  = 1'b0;
        out_load = 1'b0;
        bypass   = 1'b0;
        if (i_flush) begin
            state_n = ST_EMPTY;
        end else if (state == ST_EMPTY || hs) begin
            if (!fifo_empty) begin
                fifo_rd  = 1'b1;
                fifo_wr  = accept;
                out_load = 1'b1;
                state_n  = ST_FULL;
            end else if (accept) begin
                // Nothing queued ahead: the new beat goes straight to the output.
                out_load = 1'b1;
                bypass   = 1'b1;
                state_n  = ST_FULL;
            end else begin
                state_n  = ST_EMPTY;
            end
        end else begin
            fifo_wr = accept;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)        m_axis_tdata <= '0;
        else if (out_load) m_axis_tdata <= bypass ? i_data : fifo_rdata;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt        <= '0;
            o_intr     <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_flush) begin
            cnt        <= '0;
            o_intr     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_intr <= hs && m_axis_tlast;
            if (hs) cnt <= m_axis_tlast ? '0 : cnt + CNT_W'(1);
            if (i_data_valid && !accept) o_overflow <= 1'b1;
        end
    end

endmodule
